riscv_prefetch_buffer: RTL

RISCV_PREFETCH_BUFFER -- requirements
Module: riscv_prefetch_buffer

---
 rtl/riscv_prefetch_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/riscv_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_prefetch_buffer
// Description : Instruction prefetch buffer. Issues sequential fetches with at
//               most one transaction in flight and queues the responses in a
//               small FIFO for the ID stage. A branch flushes the FIFO and
//               redirects fetching; any in-flight response is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_prefetch_buffer #(
    parameter int          DEPTH     = 3,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_00C0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    // Counter width holds head + count (up to 2*DEPTH-1) without wrapping.
    localparam int             CW      = $clog2(DEPTH + 1) + 1;
    localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_GNT     = 2'd1;
    localparam logic [1:0] WAIT_RVALID  = 2'd2;
    localparam logic [1:0] WAIT_ABORTED = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   rsp_addr_q, rsp_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] head_q, head_d;
    logic [31:0]   mem_rdata_q [DEPTH];
    logic [31:0]   mem_rdata_d [DEPTH];
    logic [31:0]   mem_addr_q  [DEPTH];
    logic [31:0]   mem_addr_d  [DEPTH];

    logic          can_issue, push_now, pop_now, outstanding, issue_ok, granted;
    logic [CW-1:0] count_eff, fill_lhs, fill_rhs, wr_sum, wr_idx, head_inc;
    logic [1:0]    issue_next;
    logic          unused_addr_bits;

    // The low branch target bits are dropped: fetches are word aligned.
    assign unused_addr_bits = ^branch_addr_i[1:0];

    assign valid_o      = (count_q != '0);
    assign rdata_o      = mem_rdata_q[head_q[AW-1:0]];
    assign addr_o       = mem_addr_q[head_q[AW-1:0]];
    assign instr_addr_o = fetch_addr_q;
    assign busy_o       = (state_q != IDLE) || valid_o;

    // Request generation and flow control: never commit more slots than exist.
    always_comb begin
        can_issue   = (state_q == IDLE) ||
                      (((state_q == WAIT_RVALID) || (state_q == WAIT_ABORTED)) && instr_rvalid_i);
        push_now    = (state_q == WAIT_RVALID) && instr_rvalid_i && !branch_i;
        pop_now     = valid_o && ready_i && !branch_i;
        outstanding = (state_q == WAIT_RVALID) && !instr_rvalid_i && !branch_i;
        // A branch empties the FIFO at this edge, so the slots are free again.
        count_eff   = branch_i ? '0 : count_q;
        fill_lhs    = count_eff + CW'(outstanding) + CW'(push_now);
        fill_rhs    = DEPTH_C + CW'(pop_now);
        issue_ok    = req_i && (fill_lhs < fill_rhs);
        instr_req_o = (state_q == WAIT_GNT) || (can_issue && issue_ok);
        granted     = instr_req_o && instr_gnt_i;
        issue_next  = granted     ? (branch_i ? WAIT_ABORTED : WAIT_RVALID) :
                      instr_req_o ? WAIT_GNT : IDLE;
    end

    // Fetch FSM and fetch/response address tracking.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        rsp_addr_d   = rsp_addr_q;
        if (granted) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
            rsp_addr_d   = fetch_addr_q;
        end
        if (branch_i) begin
            fetch_addr_d = {branch_addr_i[31:2], 2'b00};
        end
        case (state_q)
            IDLE: state_d = issue_next;
            WAIT_GNT: begin
                if (granted)                 state_d = issue_next;
                else if (branch_i && !req_i) state_d = IDLE;
            end
            WAIT_RVALID: begin
                if (instr_rvalid_i) state_d = issue_next;
                else if (branch_i)  state_d = WAIT_ABORTED;
            end
            WAIT_ABORTED: begin
                if (instr_rvalid_i) state_d = issue_next;
            end
            default: state_d = IDLE;
        endcase
    end

    // Circular FIFO: write at head+count, read at head, flush on branch.
    always_comb begin
        mem_rdata_d = mem_rdata_q;
        mem_addr_d  = mem_addr_q;
        count_d     = count_q;
        head_d      = head_q;
        wr_sum      = head_q + count_q;
        wr_idx      = (wr_sum >= DEPTH_C) ? (wr_sum - DEPTH_C) : wr_sum;
        head_inc    = head_q + CW'(1);
        if (branch_i) begin
            count_d = '0;
            head_d  = '0;
        end else begin
            if (push_now) begin
                mem_rdata_d[wr_idx[AW-1:0]] = instr_rdata_i;
                mem_addr_d[wr_idx[AW-1:0]]  = rsp_addr_q;
            end
            if (pop_now) begin
                head_d = (head_inc == DEPTH_C) ? '0 : head_inc;
            end
            count_d = count_q + CW'(push_now) - CW'(pop_now);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= {BOOT_ADDR[31:2], 2'b00};
            rsp_addr_q   <= '0;
            count_q      <= '0;
            head_q       <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            rsp_addr_q   <= rsp_addr_d;
            count_q      <= count_d;
            head_q       <= head_d;
        end
    end

    // FIFO storage needs no reset; valid_o masks stale entries.
    always_ff @(posedge clk) begin
        mem_rdata_q <= mem_rdata_d;
        mem_addr_q  <= mem_addr_d;
    end

endmodule
`default_nettype wire
